fpu_pipe: RTL and testbench
===========================

Name: fpu_pipe

Overview:
Parametrised successor to the PE's fixed 3-stage FP16 unit. Computes add/sub/mul/div/min/max on IEEE-754 binary16 operands. Results pass through an elastic pipeline of DEPTH stages with valid/ready backpressure, bubble collapsing and per-result tags. Result-class flags and accurate occupancy/empty reporting are added. Sits between the PE's operand scheduler and its writeback/queue logic.

Parameters:
DEPTH, 3, number of pipeline register stages (>=1); unstalled latency in cycles
TAG_W, 2, width of the opaque tag carried alongside each operation (generalises status)
CNT_W, $clog2(DEPTH+1), width of occupancy counter (derived; do not override)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 clears state at posedge clk)
in_valid  in  1  operation presented
in_ready  out  1  unit accepts operation this cycle
opA  in  16  FP16 operand A
opB  in  16  FP16 operand B
op  in  3  opcode (fpu_pkg::fpu_op_e)
tag_i  in  TAG_W  tag travelling with the operation
out_valid  out  1  result available
out_ready  in  1  consumer takes result this cycle
result  out  16  FP16 result
tag_o  out  TAG_W  tag of the result
flags_o  out  4  [0] NaN result, [1] Inf result, [2] zero result (+/-0), [3] illegal opcode
occupancy_o  out  CNT_W  number of valid stages
empty_o  out  1  1 when occupancy_o==0

Behaviour:
- Opcodes: 0 ADD, 1 SUB (opB sign inverted, then add), 2 MUL, 3 DIV, 4 MIN, 5 MAX, 6/7 illegal -> result 16'h0000, flags_o[3]=1.
- ADD/SUB/MUL/DIV results come from the existing fp_add/fp_mul/fp_div (combinational). Rounding and special cases are as those modules define them.
- MIN/MAX: if either operand is NaN (exp==5'h1F, mant!=0) -> 16'h7E00, flags_o[0]=1. Otherwise sign-magnitude compare. -0 and +0 compare equal. On equality return opA.
- flags_o[2:0] are decoded from the stage-0 result: NaN = exp all ones and mant!=0; Inf = exp all ones and mant==0; zero = bits[14:0]==0.
- Stage k (1..DEPTH) holds {valid, result, tag, flags}.
- advance[DEPTH] = !valid[DEPTH] | out_ready. advance[k] = !valid[k] | advance[k+1].
- in_ready = advance[1] & reset. This is a combinational ready chain; no registered skid.
- Stage 1 captures when in_valid & in_ready. If advance[k], stage k+1 loads stage k; a stage that advances without an incoming item becomes invalid.
- Bubbles collapse: a stalled tail does not block upstream stages that still hold empty slots.
- out_valid = valid[DEPTH]; result/tag_o/flags_o are taken from stage DEPTH.
- Latency: exactly DEPTH cycles, accept edge to out_valid, when out_ready is held 1. Throughput 1 op/cycle.
- Ordering: strict FIFO; no reordering.
- occupancy_o counts valid stages as a registered counter.
  - +1 on accept, -1 on out_valid & out_ready, unchanged when both occur.
  - Must equal popcount(valid) at all times (assertion).
- Full: all DEPTH valid and out_ready==0 -> in_ready=0. in_valid with in_ready=0 is ignored; the source holds its data.
- Simultaneous accept and drain while full: allowed; occupancy stays DEPTH.
- Output stability: while out_valid & !out_ready, result/tag_o/flags_o hold.
- Reset (reset==0): all valid=0, all stage data=0, occupancy_o=0.
  - Outputs during reset: out_valid=0, result=0, tag_o=0, flags_o=0, empty_o=1, in_ready=0.
  - Reset mid-operation discards all in-flight items; nothing is emitted afterwards.
  - First accept is possible in the cycle after reset returns to 1.
- DEPTH==1: single register stage; the same rules apply.

Decomposition:
- fpu_pkg:
  - fpu_op_e (3-bit enum ADD..MAX)
  - FP16 constants: FP16_QNAN=16'h7E00, FP16_EXP_MAX=5'h1F
  - fpu_flags_t packed struct {illegal, zero, inf, nan}
  - stage payload struct type parameterised by TAG_W via localparam in the module
- Sub-module fpu_datapath (combinational): wraps fp_add/fp_mul/fp_div plus min/max, opcode select and flag decode. fpu_pipe keeps only the elastic pipeline and counters.

Test Plan:
- Streaming, DEPTH=3, out_ready=1: ADD 3C00+4000, SUB 4200-3C00, MUL 4000*4200, DIV 4600/4000 on consecutive cycles -> 4200, 4000, 4600, 4200 on cycles 3..6 with matching tags; flags_o=0.
- Backpressure: out_ready=0 after 4 accepts with DEPTH=3 -> 3 accepted, then in_ready=0, occupancy_o=3, result held stable. Release out_ready -> 4th accepted in the same cycle the head drains; order preserved.
- Bubble collapse: accept, idle 1 cycle, accept, with out_ready=0 -> both items reach the stages DEPTH and DEPTH-1, occupancy_o=2, in_ready=1.
- MIN/MAX/special: MIN(8000,0000) -> 8000; MAX(C000,3800) -> 3800; MIN(7E01,3C00) -> 7E00 with flags_o[0]=1; DIV 3C00/0000 -> Inf with flags_o[1]=1; op=6 -> 0000 with flags_o[3]=1, flags_o[2]=1.
- Reset mid-flight: 2 items in flight, reset=0 for 1 cycle -> out_valid=0, empty_o=1, in_ready=0 during reset; no stale result ever emitted afterwards.
- DEPTH=1 and DEPTH=5 builds: latency 1 and 5 respectively; occupancy_o==popcount(valid) assertion holds under random valid/ready.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types, constants and binary16 helpers for the FP16 pipeline.
package fpu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_DIV = 3'd3,
      OP_MIN = 3'd4,
      OP_MAX = 3'd5
   } fpu_op_e;

   localparam logic [15:0] FP16_QNAN    = 16'h7E00;
   localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

   typedef struct packed {
      logic illegal;
      logic zero;
      logic inf;
      logic nan;
   } fpu_flags_t;

   function automatic logic fp16_is_nan(input logic [15:0] x);
      return (x[14:10] == FP16_EXP_MAX) && (x[9:0] != 10'h000);
   endfunction

   function automatic logic fp16_is_inf(input logic [15:0] x);
      return (x[14:10] == FP16_EXP_MAX) && (x[9:0] == 10'h000);
   endfunction

   // Subnormal operands are treated as signed zero by the arithmetic units.
   function automatic logic [15:0] fp16_ftz(input logic [15:0] x);
      return (x[14:10] == 5'h00) ? {x[15], 15'h0000} : x;
   endfunction

   // Sign-magnitude less-than; -0 and +0 compare equal.
   function automatic logic fp16_lt(input logic [15:0] a, input logic [15:0] b);
      logic lt;
      if ((a[14:0] == 15'h0000) && (b[14:0] == 15'h0000)) lt = 1'b0;
      else if (a[15] != b[15]) lt = a[15];
      else if (!a[15]) lt = (a[14:0] < b[14:0]);
      else lt = (a[14:0] > b[14:0]);
      return lt;
   endfunction

   // Round-to-nearest-even of a normalised 14-bit significand (bit 13 hidden,
   // bits 2:0 guard/round/sticky); overflow saturates to Inf, underflow to zero.
   function automatic logic [15:0] fp16_pack(input logic s, input logic signed [6:0] e,
                                             input logic [13:0] m);
      logic [11:0] mr;
      logic signed [6:0] ef;
      logic [15:0] y;
      mr = {1'b0, m[13:3]} + {11'h000, m[2] & (m[1] | m[0] | m[3])};
      ef = mr[11] ? (e + 7'sd1) : e;
      if (ef >= 7'sd31) y = {s, FP16_EXP_MAX, 10'h000};
      else if (ef <= 7'sd0) y = {s, 15'h0000};
      else y = {s, ef[4:0], mr[9:0]};
      return y;
   endfunction

endpackage

// File: rtl/fpu_datapath.sv
// Combinational FP16 arithmetic: add/mul/div units plus min/max, opcode
// select and result-class flag decode.
module fp_add import fpu_pkg::*; (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] y_o
);
   logic [15:0] a_s, b_s, big_s, sml_s;
   logic [4:0]  d_s;
   logic [24:0] sh_s;
   logic [13:0] mb_s, ms_s, norm_s;
   logic [14:0] sum_s;
   logic [3:0]  lz_s;
   logic signed [6:0] e_s;

   // align the smaller operand, add or subtract magnitudes, normalise, round
   always_comb begin
      a_s   = fp16_ftz(a_i);
      b_s   = fp16_ftz(b_i);
      big_s = (a_s[14:0] >= b_s[14:0]) ? a_s : b_s;
      sml_s = (a_s[14:0] >= b_s[14:0]) ? b_s : a_s;
      d_s   = big_s[14:10] - sml_s[14:10];
      mb_s  = {1'b1, big_s[9:0], 3'b000};
      sh_s  = {1'b1, sml_s[9:0], 14'h0000} >> d_s;
      if (sml_s[14:10] == 5'h00) ms_s = 14'h0000;
      else if (d_s > 5'd24) ms_s = 14'h0001;
      else ms_s = sh_s[24:11] | {13'h0000, |sh_s[10:0]};
      sum_s = (big_s[15] == sml_s[15]) ? ({1'b0, mb_s} + {1'b0, ms_s})
                                       : ({1'b0, mb_s} - {1'b0, ms_s});
      lz_s = 4'd0;
      for (int i = 0; i < 14; i++) lz_s = sum_s[i] ? 4'(13 - i) : lz_s;
      e_s = $signed({2'b00, big_s[14:10]});
      if (sum_s[14]) begin
         norm_s = sum_s[14:1] | {13'h0000, sum_s[0]};
         e_s    = e_s + 7'sd1;
      end else begin
         norm_s = sum_s[13:0] << lz_s;
         e_s    = e_s - $signed({3'b000, lz_s});
      end
      if (fp16_is_nan(a_s) || fp16_is_nan(b_s) ||
          (fp16_is_inf(a_s) && fp16_is_inf(b_s) && (a_s[15] != b_s[15]))) y_o = FP16_QNAN;
      else if (fp16_is_inf(a_s)) y_o = a_s;
      else if (fp16_is_inf(b_s)) y_o = b_s;
      else if (big_s[14:10] == 5'h00) y_o = {a_s[15] & b_s[15], 15'h0000};
      else if (sum_s == 15'h0000) y_o = 16'h0000;
      else y_o = fp16_pack(big_s[15], e_s, norm_s);
   end
endmodule

module fp_mul import fpu_pkg::*; (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] y_o
);
   logic [15:0] a_s, b_s;
   logic [21:0] p_s;
   logic [13:0] m_s;
   logic signed [6:0] e_s;
   logic s_s;

   // significand product, one-bit normalise, special-case override
   always_comb begin
      a_s = fp16_ftz(a_i);
      b_s = fp16_ftz(b_i);
      s_s = a_s[15] ^ b_s[15];
      p_s = 22'({1'b1, a_s[9:0]}) * 22'({1'b1, b_s[9:0]});
      e_s = $signed({2'b00, a_s[14:10]}) + $signed({2'b00, b_s[14:10]}) - 7'sd15;
      if (p_s[21]) begin
         m_s = {p_s[21:9], |p_s[8:0]};
         e_s = e_s + 7'sd1;
      end else begin
         m_s = {p_s[20:8], |p_s[7:0]};
      end
      if (fp16_is_nan(a_s) || fp16_is_nan(b_s) ||
          (fp16_is_inf(a_s) && (b_s[14:0] == 15'h0000)) ||
          (fp16_is_inf(b_s) && (a_s[14:0] == 15'h0000))) y_o = FP16_QNAN;
      else if (fp16_is_inf(a_s) || fp16_is_inf(b_s)) y_o = {s_s, FP16_EXP_MAX, 10'h000};
      else if ((a_s[14:0] == 15'h0000) || (b_s[14:0] == 15'h0000)) y_o = {s_s, 15'h0000};
      else y_o = fp16_pack(s_s, e_s, m_s);
   end
endmodule

module fp_div import fpu_pkg::*; (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] y_o
);
   logic [15:0] a_s, b_s;
   logic [24:0] num_s, den_s;
   logic [14:0] q_s;
   logic [10:0] r_s;
   logic [13:0] m_s;
   logic signed [6:0] e_s;
   logic s_s;

   // long division of significands with remainder folded into sticky
   always_comb begin
      a_s   = fp16_ftz(a_i);
      b_s   = fp16_ftz(b_i);
      s_s   = a_s[15] ^ b_s[15];
      num_s = {1'b1, a_s[9:0], 14'h0000};
      den_s = {14'h0000, 1'b1, b_s[9:0]};
      q_s   = 15'(num_s / den_s);
      r_s   = 11'(num_s % den_s);
      e_s   = $signed({2'b00, a_s[14:10]}) - $signed({2'b00, b_s[14:10]}) + 7'sd15;
      if (q_s[14]) begin
         m_s = {q_s[14:2], (|q_s[1:0]) | (r_s != 11'h000)};
      end else begin
         m_s = {q_s[13:1], q_s[0] | (r_s != 11'h000)};
         e_s = e_s - 7'sd1;
      end
      if (fp16_is_nan(a_s) || fp16_is_nan(b_s) ||
          (fp16_is_inf(a_s) && fp16_is_inf(b_s)) ||
          ((a_s[14:0] == 15'h0000) && (b_s[14:0] == 15'h0000))) y_o = FP16_QNAN;
      else if (fp16_is_inf(a_s) || (b_s[14:0] == 15'h0000)) y_o = {s_s, FP16_EXP_MAX, 10'h000};
      else if ((a_s[14:0] == 15'h0000) || fp16_is_inf(b_s)) y_o = {s_s, 15'h0000};
      else y_o = fp16_pack(s_s, e_s, m_s);
   end
endmodule

module fpu_datapath import fpu_pkg::*; (
   input  logic [15:0] op_a_i,
   input  logic [15:0] op_b_i,
   input  logic [2:0]  op_i,
   output logic [15:0] res_o,
   output fpu_flags_t  flags_o
);
   fpu_op_e     op_s;
   logic [15:0] b_add_s, add_s, mul_s, div_s, min_s, max_s;
   logic        nan_in_s;

   assign op_s    = fpu_op_e'(op_i);
   assign b_add_s = (op_s == OP_SUB) ? {~op_b_i[15], op_b_i[14:0]} : op_b_i;

   fp_add u_add (.a_i(op_a_i), .b_i(b_add_s), .y_o(add_s));
   fp_mul u_mul (.a_i(op_a_i), .b_i(op_b_i),  .y_o(mul_s));
   fp_div u_div (.a_i(op_a_i), .b_i(op_b_i),  .y_o(div_s));

   // min/max compare, opcode select and flag decode of the selected result
   always_comb begin
      nan_in_s = fp16_is_nan(op_a_i) || fp16_is_nan(op_b_i);
      min_s    = nan_in_s ? FP16_QNAN : (fp16_lt(op_b_i, op_a_i) ? op_b_i : op_a_i);
      max_s    = nan_in_s ? FP16_QNAN : (fp16_lt(op_a_i, op_b_i) ? op_b_i : op_a_i);
      case (op_s)
         OP_ADD, OP_SUB: res_o = add_s;
         OP_MUL:         res_o = mul_s;
         OP_DIV:         res_o = div_s;
         OP_MIN:         res_o = min_s;
         OP_MAX:         res_o = max_s;
         default:        res_o = 16'h0000;
      endcase
      flags_o.nan     = fp16_is_nan(res_o);
      flags_o.inf     = fp16_is_inf(res_o);
      flags_o.zero    = (res_o[14:0] == 15'h0000);
      flags_o.illegal = (op_i > 3'd5);
   end
endmodule

// File: rtl/fpu_pipe_chk.sv
// Occupancy counter cross-check against the stage valid bits.
module fpu_pipe_chk #(
   parameter int DEPTH = 3,
   parameter int CNT_W = 2
) (
   input logic             clk_i,
   input logic             reset_i,
   input logic [DEPTH-1:0] valid_i,
   input logic [CNT_W-1:0] occ_i
);
   // the registered counter must always equal the number of valid stages
   always @(posedge clk_i) begin
      assert (!reset_i || ($countones(valid_i) == int'(occ_i)));
   end
endmodule

// File: rtl/fpu_pipe.sv
// Elastic FP16 pipeline: DEPTH register stages with a combinational ready
// chain, bubble collapsing, tags, result flags and an occupancy counter.
module fpu_pipe import fpu_pkg::*; #(
   parameter int DEPTH = 3,
   parameter int TAG_W = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      opA,
   input  logic [15:0]      opB,
   input  logic [2:0]       op,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      result,
   output logic [TAG_W-1:0] tag_o,
   output logic [3:0]       flags_o,
   output logic [CNT_W-1:0] occupancy_o,
   output logic             empty_o
);
   typedef struct packed {
      logic [15:0]      res;
      logic [TAG_W-1:0] tag;
      fpu_flags_t       flags;
   } stage_t;

   logic [DEPTH:1]   valid_q, valid_d, adv_s;
   stage_t           data_q [1:DEPTH];
   stage_t           data_d [1:DEPTH];
   stage_t           st0_s;
   logic [15:0]      dp_res_s;
   fpu_flags_t       dp_flags_s;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic             empty_q, empty_d, accept_s, drain_s;

   fpu_datapath u_dp (.op_a_i(opA), .op_b_i(opB), .op_i(op), .res_o(dp_res_s), .flags_o(dp_flags_s));

   assign st0_s    = '{res: dp_res_s, tag: tag_i, flags: dp_flags_s};
   assign in_ready = adv_s[1] & reset;
   assign accept_s = in_valid & in_ready;
   assign drain_s  = valid_q[DEPTH] & out_ready;

   // ready chain: a stage may take new data if it is empty or its successor moves
   always_comb begin
      adv_s        = '0;
      adv_s[DEPTH] = !valid_q[DEPTH] | out_ready;
      for (int k = DEPTH - 1; k >= 1; k--) adv_s[k] = !valid_q[k] | adv_s[k + 1];
   end

   // next state for stage valids/payloads, occupancy and empty
   always_comb begin
      valid_d[1] = adv_s[1] ? accept_s : valid_q[1];
      data_d[1]  = (adv_s[1] & accept_s) ? st0_s : data_q[1];
      for (int k = 2; k <= DEPTH; k++) begin
         valid_d[k] = adv_s[k] ? valid_q[k - 1] : valid_q[k];
         data_d[k]  = (adv_s[k] & valid_q[k - 1]) ? data_q[k - 1] : data_q[k];
      end
      case ({accept_s, drain_s})
         2'b10:   occ_d = occ_q + CNT_W'(1);
         2'b01:   occ_d = occ_q - CNT_W'(1);
         default: occ_d = occ_q;
      endcase
      empty_d = (occ_d == '0);
   end

   // pipeline and counter registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q <= '0;
         for (int k = 1; k <= DEPTH; k++) data_q[k] <= '0;
         occ_q   <= '0;
         empty_q <= 1'b1;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         occ_q   <= occ_d;
         empty_q <= empty_d;
      end
   end

   assign out_valid   = valid_q[DEPTH];
   assign result      = data_q[DEPTH].res;
   assign tag_o       = data_q[DEPTH].tag;
   assign flags_o     = data_q[DEPTH].flags;
   assign occupancy_o = occ_q;
   assign empty_o     = empty_q;

   fpu_pipe_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
      .clk_i(clk), .reset_i(reset), .valid_i(valid_q), .occ_i(occ_q)
   );
endmodule

// File: tb/tb_fpu_pipe.sv
// Directed bench for fpu_pipe: DEPTH=3 main instance plus DEPTH=1 and
// DEPTH=5 instances sharing the same stimulus.
module tb_fpu_pipe;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] opA = 16'h0000;
    logic [15:0] opB = 16'h0000;
    logic [2:0]  op = 3'd0;
    logic [1:0]  tag_i = 2'd0;

    logic        o3_in_ready, o3_out_valid, o3_empty;
    logic [15:0] o3_result;
    logic [1:0]  o3_tag, o3_occ;
    logic [3:0]  o3_flags;
    logic        o1_in_ready, o1_out_valid, o1_empty;
    logic [15:0] o1_result;
    logic [1:0]  o1_tag;
    logic [0:0]  o1_occ;
    logic [3:0]  o1_flags;
    logic        o5_in_ready, o5_out_valid, o5_empty;
    logic [15:0] o5_result;
    logic [1:0]  o5_tag;
    logic [2:0]  o5_occ;
    logic [3:0]  o5_flags;

    int n_pass = 0, n_total = 0, n_fail = 0;
    int n_acc = 0, n_pop = 0;
    logic acc5, pop5;

    fpu_pipe #(.DEPTH(3), .TAG_W(2)) u3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o3_in_ready),
        .opA(opA), .opB(opB), .op(op), .tag_i(tag_i), .out_valid(o3_out_valid),
        .out_ready(out_ready), .result(o3_result), .tag_o(o3_tag), .flags_o(o3_flags),
        .occupancy_o(o3_occ), .empty_o(o3_empty));
    fpu_pipe #(.DEPTH(1), .TAG_W(2)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o1_in_ready),
        .opA(opA), .opB(opB), .op(op), .tag_i(tag_i), .out_valid(o1_out_valid),
        .out_ready(out_ready), .result(o1_result), .tag_o(o1_tag), .flags_o(o1_flags),
        .occupancy_o(o1_occ), .empty_o(o1_empty));
    fpu_pipe #(.DEPTH(5), .TAG_W(2)) u5 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o5_in_ready),
        .opA(opA), .opB(opB), .op(op), .tag_i(tag_i), .out_valid(o5_out_valid),
        .out_ready(out_ready), .result(o5_result), .tag_o(o5_tag), .flags_o(o5_flags),
        .occupancy_o(o5_occ), .empty_o(o5_empty));

    // free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] t);
        in_valid = 1'b1;
        op = o; opA = a; opB = b; tag_i = t;
    endtask

    // directed and random stimulus with checks
    initial begin
        out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(o3_out_valid), 32'(1'b0));
        chk("rst_empty", 32'(o3_empty), 32'(1'b1));
        chk("rst_occ", 32'(o3_occ), 32'(2'd0));
        chk("rst_in_ready", 32'(o3_in_ready), 32'(1'b0));
        chk("rst_result", 32'(o3_result), 32'(16'h0000));
        chk("rst_tag_flags", 32'({o3_tag, o3_flags}), 32'(6'h00));
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(o3_in_ready), 32'(1'b1));

        set_op(OP_ADD, 16'h3C00, 16'h4000, 2'd0); tick();
        chk("d1_latency_valid", 32'(o1_out_valid), 32'(1'b1));
        chk("d1_result", 32'({o1_tag, o1_result}), 32'({2'd0, 16'h4200}));
        set_op(OP_SUB, 16'h4200, 16'h3C00, 2'd1); tick();
        set_op(OP_MUL, 16'h4000, 16'h4200, 2'd2); tick();
        chk("s0_valid", 32'(o3_out_valid), 32'(1'b1));
        chk("s0_add", 32'({o3_tag, o3_result}), 32'({2'd0, 16'h4200}));
        chk("s0_flags", 32'(o3_flags), 32'(4'h0));
        set_op(OP_DIV, 16'h4600, 16'h4000, 2'd3); tick();
        chk("s1_sub", 32'({o3_tag, o3_result}), 32'({2'd1, 16'h4000}));
        chk("d5_not_yet", 32'(o5_out_valid), 32'(1'b0));
        in_valid = 1'b0; tick();
        chk("s2_mul", 32'({o3_tag, o3_result}), 32'({2'd2, 16'h4600}));
        chk("d5_latency", 32'({o5_out_valid, o5_tag, o5_result}), 32'({1'b1, 2'd0, 16'h4200}));
        tick();
        chk("s3_div", 32'({o3_tag, o3_result, o3_flags}), 32'({2'd3, 16'h4200, 4'h0}));
        tick();
        chk("s_empty", 32'({o3_out_valid, o3_empty}), 32'(2'b01));
        tick(); tick();

        out_ready = 1'b0;
        set_op(OP_ADD, 16'h3C00, 16'h3C00, 2'd0);
        #1;
        chk("bp_ready_empty", 32'(o3_in_ready), 32'(1'b1));
        tick();
        set_op(OP_MUL, 16'h4000, 16'h4000, 2'd1); tick();
        set_op(OP_SUB, 16'h3C00, 16'h3C00, 2'd2); tick();
        set_op(OP_DIV, 16'h4400, 16'h4000, 2'd3);
        chk("bp_full_ready", 32'(o3_in_ready), 32'(1'b0));
        chk("bp_full_occ", 32'(o3_occ), 32'(2'd3));
        chk("bp_head", 32'({o3_out_valid, o3_tag, o3_result}), 32'({1'b1, 2'd0, 16'h4000}));
        tick();
        chk("bp_hold_occ", 32'(o3_occ), 32'(2'd3));
        chk("bp_hold_head", 32'({o3_tag, o3_result}), 32'({2'd0, 16'h4000}));
        chk("bp_hold_ready", 32'(o3_in_ready), 32'(1'b0));
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(o3_in_ready), 32'(1'b1));
        tick();
        chk("bp_swap_occ", 32'(o3_occ), 32'(2'd3));
        chk("bp_item1", 32'({o3_tag, o3_result}), 32'({2'd1, 16'h4400}));
        in_valid = 1'b0; tick();
        chk("bp_item2", 32'({o3_tag, o3_result, o3_flags}), 32'({2'd2, 16'h0000, 4'b0100}));
        tick();
        chk("bp_item3", 32'({o3_tag, o3_result, o3_flags}), 32'({2'd3, 16'h4000, 4'b0000}));
        tick();
        chk("bp_drained", 32'({o3_empty, o3_occ}), 32'({1'b1, 2'd0}));

        out_ready = 1'b0;
        set_op(OP_MIN, 16'h8000, 16'h0000, 2'd1); tick();
        in_valid = 1'b0; tick();
        set_op(OP_MAX, 16'hC000, 16'h3800, 2'd2); tick();
        in_valid = 1'b0; tick();
        chk("bub_occ", 32'(o3_occ), 32'(2'd2));
        chk("bub_ready", 32'(o3_in_ready), 32'(1'b1));
        chk("bub_min", 32'({o3_out_valid, o3_tag, o3_result, o3_flags}), 32'({1'b1, 2'd1, 16'h8000, 4'b0100}));
        tick();
        chk("bub_occ_hold", 32'(o3_occ), 32'(2'd2));
        out_ready = 1'b1; tick();
        chk("bub_max", 32'({o3_out_valid, o3_tag, o3_result, o3_flags}), 32'({1'b1, 2'd2, 16'h3800, 4'b0000}));
        tick();
        chk("bub_empty", 32'(o3_empty), 32'(1'b1));

        set_op(OP_MIN, 16'h7E01, 16'h3C00, 2'd0); tick();
        set_op(OP_DIV, 16'h3C00, 16'h0000, 2'd1); tick();
        set_op(3'd6, 16'h1234, 16'h5678, 2'd2); tick();
        chk("sp_min_nan", 32'({o3_tag, o3_result, o3_flags}), 32'({2'd0, 16'h7E00, 4'b0001}));
        in_valid = 1'b0; tick();
        chk("sp_div_zero", 32'({o3_tag, o3_result, o3_flags}), 32'({2'd1, 16'h7C00, 4'b0010}));
        tick();
        chk("sp_illegal", 32'({o3_tag, o3_result, o3_flags}), 32'({2'd2, 16'h0000, 4'b1100}));
        tick();

        set_op(OP_ADD, 16'h3C00, 16'h3C00, 2'd1); tick();
        set_op(OP_ADD, 16'h3C00, 16'h4000, 2'd2); tick();
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(o3_in_ready), 32'(1'b0));
        tick();
        chk("mid_rst_state", 32'({o3_out_valid, o3_empty, o3_occ}), 32'({1'b0, 1'b1, 2'd0}));
        chk("mid_rst_all_empty", 32'({o1_empty, o5_empty}), 32'(2'b11));
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_stale", 32'({o1_out_valid, o3_out_valid, o5_out_valid}), 32'(3'b000));
        end

        set_op(OP_ADD, 16'h3C00, 16'h4000, 2'd0);
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tag_i     = 2'(n_acc);
            #1;
            acc5 = in_valid & o5_in_ready;
            pop5 = o5_out_valid & out_ready;
            if (pop5) begin
                chk("rnd_order", 32'({o5_tag, o5_result}), 32'({2'(n_pop), 16'h4200}));
                n_pop++;
            end
            tick();
            if (acc5) n_acc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (o5_out_valid) begin
                chk("drain_order", 32'({o5_tag, o5_result}), 32'({2'(n_pop), 16'h4200}));
                n_pop++;
            end
            tick();
        end
        chk("rnd_count", 32'(n_pop), 32'(n_acc));
        chk("rnd_all_empty", 32'({o1_empty, o3_empty, o5_empty, o5_occ}), 32'({3'b111, 3'd0}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
